// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA timing / test-pattern source:
//   - default 640x480@60 timing constants and the derived line/frame totals
//   - pattern_mode_t: pattern selector (BARS, GRAD, XOR, RAMP)
//   - BAR_RGB: colour-bar palette, index 0 = leftmost bar
package vga_timing_pkg;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Width of the h/v counters; wide enough for any practical VGA-class mode.
    localparam int COORD_W = 12;

    // Colour bars are a fixed 80 pixels wide regardless of the visible width.
    localparam int BAR_WIDTH = 80;

    typedef enum logic [1:0] {
        BARS = 2'd0,
        GRAD = 2'd1,
        XOR  = 2'd2,
        RAMP = 2'd3
    } pattern_mode_t;

    // {R,G,B} per bar; element [0] is the leftmost (white) bar.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000,   // 7 black
        24'h0000FF,   // 6 blue
        24'hFF0000,   // 5 red
        24'hFF00FF,   // 4 magenta
        24'h00FF00,   // 3 green
        24'h00FFFF,   // 2 cyan
        24'hFFFF00,   // 1 yellow
        24'hFFFFFF    // 0 white
    };

endpackage

// File: rtl/vga_pattern.sv
// vga_pattern
// Purely combinational pixel generator.
// Ports:
//   x     in  COORD_W  current column (h counter)
//   y     in  8        low byte of the current line (v counter)
//   f     in  8        frame counter value
//   mode  in  2        latched pattern mode
//   blank in  1        high outside the visible area; forces black
//   r,g,b out 8 each   pixel codes
module vga_pattern
    import vga_timing_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [7:0]         y,
    input  logic [7:0]         f,
    input  pattern_mode_t      mode,
    input  logic               blank,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b
);

    localparam logic [COORD_W-1:0] BAR_W = COORD_W'(BAR_WIDTH);

    logic [2:0]  bar;
    logic [23:0] bar_rgb;
    logic [7:0]  xy;

    // Only bars 0..7 occur inside a 640-wide visible area; anything beyond
    // is blanked, so truncating the quotient is harmless.
    assign bar     = 3'(x / BAR_W);
    assign bar_rgb = BAR_RGB[bar];
    assign xy      = x[7:0] ^ y;

    always_comb begin
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        if (!blank) begin
            case (mode)
                BARS: {r, g, b} = bar_rgb;
                GRAD: begin
                    r = x[7:0];
                    g = y;
                    b = f;
                end
                XOR: begin
                    r = xy;
                    g = xy + f;
                    b = x[8:1];
                end
                RAMP: begin
                    r = f;
                    g = f;
                    b = f;
                end
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_pattern.sv
// vga_timing_pattern
// VGA timing generator with test-pattern source for a differential CS-DAC.
// Ports:
//   clk              in   pixel clock
//   rst              in   asynchronous active-high reset
//   mode[1:0]        in   pattern select, latched at end of frame
//   hsync, vsync     out  active-low syncs
//   hblank, vblank   out  high outside visible columns / lines
//   r, g, b [7:0]    out  pixel codes
//   rn, gn, bn [7:0] out  bitwise complements of r, g, b
//   frame[7:0]       out  free-running frame counter
// All outputs come straight from flops clocked on the same edge, one clock
// after the h/v state they describe.
module vga_timing_pattern
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic [7:0] rn,
    output logic [7:0] gn,
    output logic [7:0] bn,
    output logic [7:0] frame
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC);

    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    pattern_mode_t      mode_q;

    logic       h_end;
    logic       v_end;
    logic       frame_end;
    logic       hblank_next;
    logic       vblank_next;
    logic       hsync_next;
    logic       vsync_next;
    logic [7:0] r_next;
    logic [7:0] g_next;
    logic [7:0] b_next;

    assign h_end     = (h == H_LAST);
    assign v_end     = (v == V_LAST);
    assign frame_end = h_end && v_end;

    // Counters, frame count and mode latch. Mode is only sampled at the
    // last pixel of a frame so a pattern never changes mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h      <= '0;
            v      <= '0;
            frame  <= 8'h00;
            mode_q <= BARS;
        end else begin
            if (h_end) begin
                h <= '0;
                v <= v_end ? '0 : v + COORD_W'(1);
            end else begin
                h <= h + COORD_W'(1);
            end
            if (frame_end) begin
                frame  <= frame + 8'd1;
                mode_q <= pattern_mode_t'(mode);
            end
        end
    end

    assign hblank_next = (h >= H_VIS_C);
    assign vblank_next = (v >= V_VIS_C);
    assign hsync_next  = !((h >= HS_START) && (h < HS_END));
    assign vsync_next  = !((v >= VS_START) && (v < VS_END));

    vga_pattern u_pattern (
        .x     (h),
        .y     (v[7:0]),
        .f     (frame),
        .mode  (mode_q),
        .blank (hblank_next || vblank_next),
        .r     (r_next),
        .g     (g_next),
        .b     (b_next)
    );

    // Complements get their own flops (reset to all-ones) so the DAC switch
    // pairs stay exactly complementary on every cycle, reset included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            hblank <= 1'b1;
            vblank <= 1'b1;
            r      <= 8'h00;
            g      <= 8'h00;
            b      <= 8'h00;
            rn     <= 8'hFF;
            gn     <= 8'hFF;
            bn     <= 8'hFF;
        end else begin
            hsync  <= hsync_next;
            vsync  <= vsync_next;
            hblank <= hblank_next;
            vblank <= vblank_next;
            r      <= r_next;
            g      <= g_next;
            b      <= b_next;
            rn     <= ~r_next;
            gn     <= ~g_next;
            bn     <= ~b_next;
        end
    end

endmodule
